fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch front end.
//   Keeps a byte-address PC, issues one program-memory read per cycle while
//   there is room, and buffers returned words with their addresses in a
//   2-entry FIFO for decode. A branch redirect flushes the buffer and
//   squashes the read in flight.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_addr/imem_req           read address and request strobe to memory
//   imem_data                    word returned one cycle after a request
//   branch_taken/branch_target   single-cycle redirect from execute
//   instr/instr_pc/instr_valid   FIFO head presented to decode
//   instr_ready                  decode accepts the head when high
module fetch_unit #(
  parameter int          PC_WIDTH  = 8,
  parameter int          OPD_WIDTH = 32,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_WIDTH-1:0]  imem_addr,
  output logic                 imem_req,
  input  logic [31:0]          imem_data,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic [31:0]          instr,
  output logic [OPD_WIDTH-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready
);

  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [1:0]                count_q, count_d;
  logic                      inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]       inflight_pc_q, inflight_pc_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [1:0][31:0]          buf_data_q, buf_data_d;
  logic [1:0][PC_WIDTH-1:0]  buf_pc_q, buf_pc_d;

  logic                      pop_s;
  logic                      wr_ptr_s;
  logic [2:0]                occupancy_s;
  logic [PC_WIDTH-1:0]       target_s;

  // Word-align the redirect target (low two bits forced to zero).
  assign target_s = branch_target & ~PC_WIDTH'(3);

  // Write slot sits one past the head when a single entry is held.
  assign wr_ptr_s = rd_ptr_q ^ count_q[0];

  // Valid is suppressed during reset so nothing is handed over that cycle.
  assign instr_valid = (count_q != 2'd0) && !rst;
  assign pop_s       = instr_valid && instr_ready;

  // Entries held plus the word on its way, less what leaves this cycle; a new
  // request is only allowed if its word is guaranteed a free slot.
  assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign imem_req    = !rst && !branch_taken && (occupancy_s < 3'd2);
  assign imem_addr   = pc_q;

  // Head of the FIFO, forced to zero while it is empty.
  assign instr    = (count_q != 2'd0) ? buf_data_q[rd_ptr_q] : 32'd0;
  assign instr_pc = (count_q != 2'd0) ? OPD_WIDTH'(buf_pc_q[rd_ptr_q]) : '0;

  // Next-state logic: redirect flush, or normal issue/push/pop.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    inflight_d    = imem_req;
    inflight_pc_d = pc_q;
    rd_ptr_d      = rd_ptr_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    if (branch_taken) begin
      // Redirect wins over any pop and squashes the word in flight.
      pc_d       = target_s;
      count_d    = 2'd0;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
    end else begin
      if (imem_req) begin
        pc_d = pc_q + PC_WIDTH'(4);
      end else begin
        pc_d = pc_q;
      end
      if (inflight_q) begin
        buf_data_d[wr_ptr_s] = imem_data;
        buf_pc_d[wr_ptr_s]   = inflight_pc_q;
      end else begin
        buf_data_d = buf_data_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, inflight_q} - {1'b0, pop_s};
    end
  end

  // State registers with synchronous reset; reset also drops the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= PC_WIDTH'(RESET_PC);
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      buf_data_q    <= '0;
      buf_pc_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_WIDTH(8), .OPD_WIDTH(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'h1000_0000 + {26'd0, a[7:2]};
  endfunction

  // Program memory: one-cycle read latency, junk when not requested.
  always @(posedge clk) imem_data <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;

  // Reference model: list of fetched-but-undelivered words with issue cycle.
  typedef struct { logic [7:0] pc; int cyc; } pend_t;
  pend_t      pend[$];
  logic [7:0] fetch_pc;
  int         cyc;

  function automatic logic exp_valid();
    return !rst && pend.size() > 0 && (cyc - pend[0].cyc) >= 2;
  endfunction

  // Advance one clock and update the model from the inputs applied this cycle.
  task automatic step();
    logic p_rst, p_br, p_pop, p_req;
    logic [7:0] p_tgt;
    p_rst = rst; p_br = branch_taken; p_tgt = branch_target;
    p_pop = exp_valid() && instr_ready;
    p_req = !p_rst && !p_br && ((pend.size() - (p_pop ? 1 : 0)) < 2);
    @(posedge clk); #1;
    if (p_rst) begin
      pend.delete(); fetch_pc = 8'h00;
    end else if (p_br) begin
      pend.delete(); fetch_pc = p_tgt & 8'hFC;
    end else begin
      if (p_pop) void'(pend.pop_front());
      if (p_req) begin
        pend.push_back('{fetch_pc, cyc});
        fetch_pc = fetch_pc + 8'd4;
      end
    end
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1; branch_taken = 1'b0; step();
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b1; step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin errors++; $display("FAIL reset_zero got %h/%h exp 0/0", instr, instr_pc); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset(); instr_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL stream_first_req got %b@%h exp 1@00", imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got %b exp 0", instr_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== 32'h1000_0000 + 32'(k)) begin
        errors++; $display("FAIL stream_seq%0d got v=%b pc=%h i=%h exp pc=%h", k, instr_valid, instr_pc, instr, 4*k);
      end
      step();
    end
  endtask

  task automatic test_stall();
    apply_reset(); instr_ready = 1'b0; #1;
    repeat (5) step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h08) begin errors++; $display("FAIL stall_hold got %b@%h exp 0@08", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL stall_head got v=%b pc=%h exp 1/0", instr_valid, instr_pc); end
    instr_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4*k)) begin
        errors++; $display("FAIL stall_release%0d got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, 4*k);
      end
      step();
    end
  endtask

  task automatic test_branch();
    apply_reset(); instr_ready = 1'b0; #1;
    repeat (5) step();
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h42; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL branch_noreq got %b exp 0", imem_req); end
    step(); branch_taken = 1'b0; #1;
    checks++; if (imem_addr !== 8'h40 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL branch_redirect got %b@%h v=%b exp 1@40 v=0", imem_req, imem_addr, instr_valid);
    end
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== word(8'h40)) begin
      errors++; $display("FAIL branch_first got v=%b pc=%h i=%h exp pc=40", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
    branch_taken = 1'b1; branch_target = 8'hF8; step();
    branch_taken = 1'b0; instr_ready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6 && !instr_valid; i++) step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== {24'd0, exp_pc[k]} || instr !== word(exp_pc[k])) begin
        errors++; $display("FAIL wrap%0d got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, exp_pc[k]);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(); instr_ready = 1'b1; #1;
    repeat (6) step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", instr_valid); end
    rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_during got req=%b v=%b exp 0/0", imem_req, instr_valid); end
    step(); rst = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h00 || imem_req !== 1'b1) begin
      errors++; $display("FAIL midrst_after got v=%b req=%b@%h exp 0 1@00", instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 6 && !instr_valid; i++) step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h1000_0000) begin
      errors++; $display("FAIL midrst_first got v=%b pc=%h i=%h exp pc=0", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_double_branch();
    instr_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 8'h10; step();
    branch_target = 8'h20; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL dbl_between got %b exp 0", instr_valid); end
    step(); branch_taken = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h20) begin errors++; $display("FAIL dbl_addr got v=%b a=%h exp 0/20", instr_valid, imem_addr); end
    for (int i = 0; i < 6 && !instr_valid; i++) step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin errors++; $display("FAIL dbl_first got v=%b pc=%h exp 20", instr_valid, instr_pc); end
  endtask

  task automatic test_random();
    logic ev, ereq;
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(99) < 2);
      branch_taken  = ($urandom_range(99) < 5);
      branch_target = 8'($urandom);
      instr_ready   = ($urandom_range(99) < 70);
      #1;
      ev   = exp_valid();
      ereq = !rst && !branch_taken && ((pend.size() - ((ev && instr_ready) ? 1 : 0)) < 2);
      checks++; if (instr_valid !== ev) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", n, instr_valid, ev); end
      checks++; if (imem_req !== ereq) begin errors++; $display("FAIL rnd_req c%0d got %b exp %b", n, imem_req, ereq); end
      checks++; if (imem_addr !== fetch_pc) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", n, imem_addr, fetch_pc); end
      if (ev) begin
        checks++;
        if (instr_pc !== {24'd0, pend[0].pc} || instr !== word(pend[0].pc)) begin
          errors++; $display("FAIL rnd_head c%0d got pc=%h i=%h exp pc=%h", n, instr_pc, instr, pend[0].pc);
        end
      end else if (!rst) begin
        checks++;
        if (instr !== 32'd0 || instr_pc !== 32'd0) begin
          errors++; $display("FAIL rnd_empty c%0d got %h/%h exp 0/0", n, instr, instr_pc);
        end
      end
      step();
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; branch_taken = 1'b0; branch_target = 8'h00;
    instr_ready = 1'b0; fetch_pc = 8'h00; cyc = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_mid_reset();
    test_double_branch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
